// File: rtl/kamus_counter_unit.sv
// Machine counter/timer CSR block: mcycle, mtime, minstret, MHPM event counters,
// COUNTINHIBIT and MTIMECMP with a registered one-cycle CSR response.
module kamus_counter_unit #(
    parameter int unsigned CNT_W    = 64,
    parameter int unsigned NUM_HPM  = 4,
    parameter int unsigned TIME_DIV = 1
) (
    input  logic                                      clk_i,
    input  logic                                      rst_ni,
    input  logic                                      csr_req_i,
    input  logic [11:0]                               csr_addr_i,
    input  logic [1:0]                                csr_op_i,
    input  logic                                      csr_wr_en_i,
    input  logic [31:0]                               csr_wdata_i,
    output logic [31:0]                               csr_rdata_o,
    output logic                                      csr_valid_o,
    output logic                                      csr_err_o,
    input  logic                                      instr_retire_i,
    input  logic [((NUM_HPM > 0) ? NUM_HPM : 1)-1:0]  hpm_event_i,
    output logic                                      timer_irq_o
);

    localparam int unsigned NCNT     = 3 + NUM_HPM;
    localparam int unsigned HI_W     = CNT_W - 32;
    localparam int unsigned PRE_W    = 8;
    localparam int unsigned IDX_W    = 7;
    localparam logic [31:0] INH_MASK = 32'((64'd1 << NCNT) - 64'd1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TIME_DIV - 1);

    localparam logic [11:0] ADDR_INH  = 12'h7C0;
    localparam logic [11:0] ADDR_CMPL = 12'h7C1;
    localparam logic [11:0] ADDR_CMPH = 12'h7C2;

    // index 0 = mcycle, 1 = mtime, 2 = minstret, 3+n = MHPMn (matches COUNTINHIBIT bits)
    logic [CNT_W-1:0] cnt_q [NCNT];
    logic [CNT_W-1:0] cnt_d [NCNT];
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [31:0]      inh_q, inh_d;
    logic [CNT_W-1:0] cmp_q, cmp_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic             irq_q, irq_d;

    logic [IDX_W-1:0] addr_idx;
    logic             in_cnt_space;
    logic             is_shadow;
    logic             is_hi;
    logic             mapped;
    logic             wr_req;
    logic             acc_err;
    logic             do_wr;
    logic [CNT_W-1:0] sel_cnt;
    logic [31:0]      old_word;
    logic [31:0]      new_word;
    logic             tick;
    logic [NCNT-1:0]  inc;

    // Address decode and old-value read mux
    always_comb begin
        addr_idx     = csr_addr_i[IDX_W-1:0];
        is_hi        = csr_addr_i[7];
        is_shadow    = (csr_addr_i[11:8] == 4'hC);
        in_cnt_space = ((csr_addr_i[11:8] == 4'hF) || is_shadow) && (addr_idx < IDX_W'(NCNT));
        wr_req       = (csr_op_i != 2'b00) && csr_wr_en_i;

        sel_cnt = '0;
        for (int k = 0; k < NCNT; k++) begin
            if (addr_idx == IDX_W'(k)) sel_cnt = cnt_q[k];
        end

        mapped   = 1'b1;
        old_word = '0;
        if (in_cnt_space) begin
            old_word = is_hi ? 32'(sel_cnt[CNT_W-1:32]) : sel_cnt[31:0];
        end else if (csr_addr_i == ADDR_INH) begin
            old_word = inh_q;
        end else if (csr_addr_i == ADDR_CMPL) begin
            old_word = cmp_q[31:0];
        end else if (csr_addr_i == ADDR_CMPH) begin
            old_word = 32'(cmp_q[CNT_W-1:32]);
        end else begin
            mapped = 1'b0;
        end

        acc_err = !mapped || (in_cnt_space && is_shadow && wr_req);
        do_wr   = csr_req_i && wr_req && !acc_err;

        case (csr_op_i)
            2'b01:   new_word = csr_wdata_i;
            2'b10:   new_word = old_word | csr_wdata_i;
            2'b11:   new_word = old_word & ~csr_wdata_i;
            default: new_word = old_word;
        endcase
    end

    // Next-state: increments first, then an access write overrides its word
    always_comb begin
        pre_d = pre_q;
        tick  = 1'b0;
        if (!inh_q[1]) begin
            if (pre_q == PRE_LAST) begin
                pre_d = '0;
                tick  = 1'b1;
            end else begin
                pre_d = pre_q + PRE_W'(1);
            end
        end

        inc    = '0;
        inc[0] = 1'b1;
        inc[1] = tick;
        inc[2] = instr_retire_i;
        for (int n = 0; n < NUM_HPM; n++) begin
            inc[3+n] = hpm_event_i[n];
        end
        inc = inc & ~inh_q[NCNT-1:0];

        for (int k = 0; k < NCNT; k++) begin
            cnt_d[k] = cnt_q[k] + CNT_W'(inc[k]);
        end
        inh_d = inh_q;
        cmp_d = cmp_q;

        if (do_wr) begin
            if (in_cnt_space) begin
                for (int k = 0; k < NCNT; k++) begin
                    if (addr_idx == IDX_W'(k)) begin
                        if (is_hi) cnt_d[k] = {HI_W'(new_word), cnt_q[k][31:0]};
                        else       cnt_d[k] = {cnt_q[k][CNT_W-1:32], new_word};
                    end
                end
            end else if (csr_addr_i == ADDR_INH) begin
                inh_d = new_word & INH_MASK;
            end else if (csr_addr_i == ADDR_CMPL) begin
                cmp_d = {cmp_q[CNT_W-1:32], new_word};
            end else begin
                cmp_d = {HI_W'(new_word), cmp_q[31:0]};
            end
        end

        valid_d = csr_req_i;
        err_d   = csr_req_i && acc_err;
        rdata_d = (csr_req_i && !acc_err) ? old_word : 32'h0;
        irq_d   = (cnt_q[1] >= cmp_q);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < NCNT; k++) begin
                cnt_q[k] <= '0;
            end
            pre_q   <= '0;
            inh_q   <= '0;
            cmp_q   <= '1;
            rdata_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            for (int k = 0; k < NCNT; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
            pre_q   <= pre_d;
            inh_q   <= inh_d;
            cmp_q   <= cmp_d;
            rdata_q <= rdata_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            irq_q   <= irq_d;
        end
    end

    assign csr_rdata_o = rdata_q;
    assign csr_valid_o = valid_q;
    assign csr_err_o   = err_q;
    assign timer_irq_o = irq_q;

endmodule

// File: doc/kamus_counter_unit.md
KAMUS_COUNTER_UNIT -- requirements
Module: kamus_counter_unit

Interface
REQ-001 SHALL have parameter CNT_W, default 64, counter width in bits, legal 33..64.
REQ-002 SHALL have parameter NUM_HPM, default 4, number of event counters, legal 0..8.
REQ-003 SHALL have parameter TIME_DIV, default 1, clk_i cycles per mtime tick, legal 1..256.
REQ-004 SHALL have port clk_i  input  1  single clock; all state on its rising edge.
REQ-005 SHALL have port rst_ni  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port csr_req_i  input  1  CSR access valid this cycle.
REQ-007 SHALL have port csr_addr_i  input  12  CSR address.
REQ-008 SHALL have port csr_op_i  input  2  funct2: 00 read-only, 01 write, 10 set, 11 clear.
REQ-009 SHALL have port csr_wr_en_i  input  1  write permitted (0 when rs1/uimm is zero for set/clear).
REQ-010 SHALL have port csr_wdata_i  input  32  write operand.
REQ-011 SHALL have port csr_rdata_o  output  32  old CSR value.
REQ-012 SHALL have port csr_valid_o  output  1  response strobe.
REQ-013 SHALL have port csr_err_o  output  1  illegal access, qualified by csr_valid_o.
REQ-014 SHALL have port instr_retire_i  input  1  one instruction retired this cycle.
REQ-015 SHALL have port hpm_event_i  input  max(NUM_HPM,1)  per-counter event pulses.
REQ-016 SHALL have port timer_irq_o  output  1  machine timer interrupt pending.

Function
REQ-017 Address map SHALL be: MCYCLE F00/F80, MTIME F01/F81, MINSTRET F02/F82, MHPMn F03+n/F83+n, low/high word respectively; read-only shadows C00-C02, C03+n, C80-C82, C83+n; MTIMECMP 7C1, MTIMECMPH 7C2; COUNTINHIBIT 7C0.
REQ-018 COUNTINHIBIT SHALL be 32 bits: bit0 cycle, bit1 time, bit2 instret, bit3+n MHPMn; other bits read 0 and ignore writes.
REQ-019 Response SHALL follow request by exactly one cycle: csr_valid_o=1, csr_rdata_o=value before any write of that access.
REQ-020 New value SHALL be wdata (01), old|wdata (10), old&~wdata (11); the write SHALL occur only when op!=00 and csr_wr_en_i=1.
REQ-021 Writes SHALL take effect at the request's clock edge; a read on the next cycle returns the new value.
REQ-022 Low-word write SHALL update bits [31:0]; high-word write SHALL update bits [CNT_W-1:32]; high-word reads SHALL zero-extend bits above CNT_W-1.
REQ-023 csr_err_o SHALL assert for unmapped addresses (including MHPMn with n>=NUM_HPM) and for any effective write to a shadow; no state SHALL change on error and csr_rdata_o SHALL be 0.
REQ-024 mcycle SHALL increment by 1 every cycle unless inhibited.
REQ-025 minstret SHALL increment by 1 on each cycle with instr_retire_i=1 unless inhibited.
REQ-026 MHPMn SHALL increment by 1 on each cycle with hpm_event_i[n]=1 unless inhibited.
REQ-027 A prescaler SHALL count 0..TIME_DIV-1 and wrap; mtime SHALL increment on wrap unless inhibited; the prescaler SHALL hold while time is inhibited.
REQ-028 All counters SHALL wrap from 2^CNT_W-1 to 0 with no flag.
REQ-029 On a cycle where a counter is both written and incremented, the written word SHALL win and the increment SHALL be dropped; the other word SHALL retain its pre-increment value.
REQ-030 timer_irq_o SHALL be registered (mtime >= mtimecmp), unsigned over CNT_W bits, updated every cycle; a write to mtimecmp or mtime SHALL affect timer_irq_o on the following cycle.
REQ-031 Back-to-back requests SHALL be accepted every cycle without stall.

Reset
REQ-032 While rst_ni=0, all counters and the prescaler SHALL be 0 and COUNTINHIBIT SHALL be 0.
REQ-033 While rst_ni=0, mtimecmp SHALL be all ones over CNT_W bits.
REQ-034 While rst_ni=0, csr_rdata_o, csr_valid_o, csr_err_o and timer_irq_o SHALL be 0.
REQ-035 Reset asserted mid-access SHALL drop the pending response; no csr_valid_o SHALL appear after release.

Verification
REQ-036 Release reset, read F00 at cycle 10 -> rdata=10 (±fixed offset documented by the bench), err=0, valid one cycle later.
REQ-037 Write F00=FFFFFFFF and F80=FFFFFFFF (CNT_W=64) -> read F00 two cycles later returns 0 or 1 per wrap timing; F80 returns 0.
REQ-038 TIME_DIV=4, mtimecmp=3 -> timer_irq_o rises on the cycle after mtime reaches 3 (~12 cycles); write MTIMECMP=100 -> irq clears next cycle.
REQ-039 Write C00 with op=01, wr_en=1 -> err=1, rdata=0, mcycle unchanged; same with wr_en=0 -> err=0, normal read.
REQ-040 COUNTINHIBIT=4 with instr_retire_i held 1 for 20 cycles -> minstret unchanged; clear bit -> increments resume next cycle.
REQ-041 NUM_HPM=2: access F05 -> err=1; simultaneous write to F03 and hpm_event_i[0]=1 -> read returns written value exactly.
